irrigation_display_scanner: RTL and testbench
=============================================

Name: irrigation_display_scanner

Overview:
- Parametrised, clocked successor to the combinational sensor-to-digit decoder of the irrigation controller.
- Captures water-level sensors (high/medium/low) and irrigation mode (sprinkler/drip) on an update strobe.
- Decodes the captured state into 7-segment glyphs and time-multiplexes them over NUM_DIGITS common-anode digits.
- Flags invalid sensor combinations with a blinking "Er" display.

Parameters:
NUM_DIGITS, 4, number of scanned digits (min 2).
SCAN_DIV, 1000, clock cycles each digit stays selected (min 1).
BLINK_FRAMES, 25, full scan frames per blink half-period in error (min 1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
update  input  1  one-cycle strobe; samples the sensor and mode inputs.
level_h  input  1  high-level sensor.
level_m  input  1  medium-level sensor.
level_l  input  1  low-level sensor.
mode_asp  input  1  sprinkler (aspersion) valve request.
mode_gt  input  1  drip (gotejamento) valve request.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
dig_sel  output  NUM_DIGITS  one-hot active-low digit enable.
err  output  1  registered invalid-state flag.
frame_tick  output  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Reset is asynchronous on rst_n low and clears every register:
  - snapshot = 0, digit index = 0, scan counter = 0, blink counter = 0, blink phase = ON.
  - Outputs: seg = 7'h7F, dig_sel = all ones, err = 0, frame_tick = 0.
- Snapshot: on a clk edge with update=1, the five inputs are latched. When update=0 the snapshot holds and input changes have no effect.
- Level decode (from snapshot), in priority order:
  - {h,m,l}=111 → "3"
  - 011 → "2"
  - 001 → "1"
  - 000 → "0"
  - any other combination (h without m, or m without l) → invalid.
- Mode decode: asp only → "A"; gt only → "d"; neither → "-"; both → invalid.
- err = registered OR of the two invalid conditions. It updates 1 cycle after the snapshot edge.
- Glyphs, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - A = 0001000, d = 0100001, - = 0111111
  - E = 0000110, r = 0101111, blank = 1111111
- Digit content:
  - Normal: digit0 = level glyph, digit1 = mode glyph, digits 2..NUM_DIGITS-1 = blank.
  - err=1: digit0 = E, digit1 = r, rest blank.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the digit index increments modulo NUM_DIGITS.
  - When the index wraps NUM_DIGITS-1→0, frame_tick is asserted for exactly that cycle.
- Outputs are registered from the current index and the decoded content:
  - dig_sel bit [index] = 0, all other bits = 1.
  - seg = glyph of the selected digit.
  - Latency: an update at edge t is visible on seg at edge t+2, when that digit is selected.
  - dig_sel goes active at the first edge after reset release (digit 0).
- Blink:
  - Runs only while err=1. The blink counter counts frame_tick pulses and toggles the phase after every BLINK_FRAMES ticks.
  - OFF phase: seg = blank. dig_sel continues scanning.
  - On the err 0→1 transition: counter = 0, phase = ON.
  - While err=0: phase held ON, counter held at 0.
- Simultaneous events: update and scan advance on the same edge are independent and both take effect. An update that clears the error takes effect at t+2 regardless of blink phase.
- Reset asserted mid-frame returns all outputs to reset values immediately, without waiting for clk.
- No gaps or glitches: exactly one dig_sel bit is low on every cycle after the first post-reset edge.

Test Plan:
- Reset release with NUM_DIGITS=4, SCAN_DIV=3 → dig_sel sequence 1110,1101,1011,0111, each held 3 cycles. frame_tick pulses once per 12 cycles. seg on digit0 = 1000000 ("0"), digit1 = 0111111.
- update with h,m,l=1,1,1 and asp=1 → at t+2: digit0 seg = 0110000, digit1 = 0001000, digits 2–3 = 1111111, err = 0.
- update with h=1,m=0,l=1 and BLINK_FRAMES=2 → err = 1 at t+1. Digits show E/r for 2 frames, then seg = 1111111 for 2 frames, alternating while dig_sel keeps scanning.
- update with asp=gt=1, levels valid → err = 1. A following update with gt only → err = 0 and digit1 = 0100001 at t+2, even if it lands mid OFF-phase.
- Input toggles without update → seg unchanged for 100 cycles. update pulsed on the same edge as a digit advance → both the new snapshot and the new index appear at the expected cycles.
- rst_n pulsed low mid-scan during error blinking → seg = 7F, dig_sel = 1111, err = 0 asynchronously. After release the scan restarts at digit0 showing "0" and "-".

Source files
------------

// File: rtl/irrigation_display_scanner.sv
// rtl/irrigation_display_scanner.sv - sensor snapshot, glyph decode and multiplexed 7-segment scan with error blink
module irrigation_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  update,
  input  logic                  level_h,
  input  logic                  level_m,
  input  logic                  level_l,
  input  logic                  mode_asp,
  input  logic                  mode_gt,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  err,
  output logic                  frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Glyphs are active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  logic [4:0]       snap;          // {h, m, l, asp, gt}
  logic             levelBad;
  logic             modeBad;
  logic [6:0]       levelGlyph;
  logic [6:0]       modeGlyph;
  logic [6:0]       levelGlyphQ;
  logic [6:0]       modeGlyphQ;
  logic [CNT_W-1:0] scanCnt;
  logic [IDX_W-1:0] digIdx;
  logic             lastSlot;
  logic             lastDigit;
  logic [BLK_W-1:0] blinkCnt;
  logic             blinkOff;
  logic [6:0]       digitGlyph;

  assign lastSlot  = (scanCnt == CNT_W'(SCAN_DIV - 1));
  assign lastDigit = (digIdx == IDX_W'(NUM_DIGITS - 1));

  // Latch the sensor and mode inputs only on the update strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
    end else if (update) begin
      snap <= {level_h, level_m, level_l, mode_asp, mode_gt};
    end
  end

  // Decode the snapshot into level/mode glyphs and their validity
  always_comb begin
    levelBad   = 1'b0;
    modeBad    = 1'b0;
    levelGlyph = GLYPH_BLANK;
    modeGlyph  = GLYPH_BLANK;
    case (snap[4:2])
      3'b111:  levelGlyph = GLYPH_3;
      3'b011:  levelGlyph = GLYPH_2;
      3'b001:  levelGlyph = GLYPH_1;
      3'b000:  levelGlyph = GLYPH_0;
      default: levelBad   = 1'b1;
    endcase
    case (snap[1:0])
      2'b10:   modeGlyph = GLYPH_A;
      2'b01:   modeGlyph = GLYPH_D;
      2'b00:   modeGlyph = GLYPH_DASH;
      default: modeBad   = 1'b1;
    endcase
  end

  // Register decode results; reset values match an all-zero snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err         <= 1'b0;
      levelGlyphQ <= GLYPH_0;
      modeGlyphQ  <= GLYPH_DASH;
    end else begin
      err         <= levelBad | modeBad;
      levelGlyphQ <= levelGlyph;
      modeGlyphQ  <= modeGlyph;
    end
  end

  // Scan counter and digit index; flag the cycle the index wraps to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scanCnt    <= '0;
      digIdx     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= lastSlot & lastDigit;
      if (lastSlot) begin
        scanCnt <= '0;
        digIdx  <= lastDigit ? '0 : digIdx + IDX_W'(1);
      end else begin
        scanCnt <= scanCnt + CNT_W'(1);
      end
    end
  end

  // Blink phase: counts frames only while in error, restarts ON otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blinkCnt <= '0;
      blinkOff <= 1'b0;
    end else if (!err) begin
      blinkCnt <= '0;
      blinkOff <= 1'b0;
    end else if (frame_tick) begin
      if (blinkCnt == BLK_W'(BLINK_FRAMES - 1)) begin
        blinkCnt <= '0;
        blinkOff <= ~blinkOff;
      end else begin
        blinkCnt <= blinkCnt + BLK_W'(1);
      end
    end
  end

  // Select the glyph for the current digit; error OFF phase forces blank
  always_comb begin
    digitGlyph = GLYPH_BLANK;
    if (digIdx == IDX_W'(0)) begin
      digitGlyph = err ? GLYPH_E : levelGlyphQ;
    end else if (digIdx == IDX_W'(1)) begin
      digitGlyph = err ? GLYPH_R : modeGlyphQ;
    end
    if (err && blinkOff) begin
      digitGlyph = GLYPH_BLANK;
    end
  end

  // Registered display outputs: exactly one active-low digit enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= GLYPH_BLANK;
      dig_sel <= '1;
    end else begin
      seg     <= digitGlyph;
      dig_sel <= ~(NUM_DIGITS'(1) << digIdx);
    end
  end

endmodule

// File: tb/tb_irrigation_display_scanner.sv
// tb/tb_irrigation_display_scanner.sv - randomized bench with behavioural display model
module tb_irrigation_display_scanner;

  localparam int N     = 4;
  localparam int S     = 3;
  localparam int BF    = 2;
  localparam int FRAME = N * S;

  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_R     = 7'b0101111;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_D     = 7'b0100001;
  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         update = 1'b0;
  logic         level_h = 1'b0;
  logic         level_m = 1'b0;
  logic         level_l = 1'b0;
  logic         mode_asp = 1'b0;
  logic         mode_gt = 1'b0;
  logic [6:0]   seg;
  logic [N-1:0] dig_sel;
  logic         err;
  logic         frame_tick;

  irrigation_display_scanner #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (S),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .update    (update),
    .level_h   (level_h),
    .level_m   (level_m),
    .level_l   (level_l),
    .mode_asp  (mode_asp),
    .mode_gt   (mode_gt),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .err       (err),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onesOf(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  // Levels are valid only as a thermometer code from the bottom up
  function automatic bit badOf(input logic [4:0] s);
    int o;
    o = onesOf(s[4:2]);
    return (int'(s[4:2]) != (1 << o) - 1) || (s[1] && s[0]);
  endfunction

  function automatic logic [6:0] glyphFor(input int d, input logic [4:0] s, input bit errOn, input bit off);
    if (errOn && off) return G_BLANK;
    if (d == 0) begin
      if (errOn) return G_E;
      case (onesOf(s[4:2]))
        0:       return 7'b1000000;
        1:       return 7'b1111001;
        2:       return 7'b0100100;
        default: return 7'b0110000;
      endcase
    end
    if (d == 1) begin
      if (errOn) return G_R;
      if (s[1]) return G_A;
      if (s[0]) return G_D;
      return G_DASH;
    end
    return G_BLANK;
  endfunction

  // Model: k counts clock edges since reset release; snapN is the snapshot N edges ago
  int         k = 0;
  int         ticks = 0;
  int         dIdx;
  logic [4:0] snap0 = '0;
  logic [4:0] snap1 = '0;
  logic [4:0] snap2 = '0;
  bit         errPrev, tickPrev, offPrev;
  logic [6:0] expSeg = 7'h7F;
  logic [N-1:0] expSel = '1;
  bit         expErr = 1'b0;
  bit         expTick = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      k = 0; ticks = 0;
      snap0 = '0; snap1 = '0; snap2 = '0;
      expSeg = 7'h7F; expSel = '1; expErr = 1'b0; expTick = 1'b0;
    end else begin
      k++;
      snap2 = snap1;
      snap1 = snap0;
      if (update) snap0 = {level_h, level_m, level_l, mode_asp, mode_gt};
      errPrev  = badOf(snap2);
      tickPrev = (k > 1) && (((k - 1) % FRAME) == 0);
      offPrev  = ((ticks / BF) % 2) == 1;
      if (!errPrev) ticks = 0;
      else if (tickPrev) ticks++;
      dIdx    = ((k - 1) / S) % N;
      expSel  = ~(N'(1) << dIdx);
      expErr  = badOf(snap1);
      expTick = (k % FRAME) == 0;
      expSeg  = glyphFor(dIdx, snap2, errPrev, offPrev);
    end
  end

  initial forever begin
    @(negedge clk);
    check("seg", seg, expSeg);
    check("dig_sel", dig_sel, expSel);
    check("err", err, expErr);
    check("frame_tick", frame_tick, expTick);
  end

  task automatic doUpdate(input logic [4:0] v);
    {level_h, level_m, level_l, mode_asp, mode_gt} = v;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic waitSel(input logic [N-1:0] target, input string name);
    int n = 0;
    while (dig_sel !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, dig_sel, target);
  endtask

  task automatic waitOff(input string name);
    int n = 0;
    while (!(dig_sel === 4'b1110 && seg === G_BLANK) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {dig_sel, seg}, {4'b1110, G_BLANK});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_seg", seg, 7'h7F);
    check("rst_sel", dig_sel, 4'hF);
    check("rst_err", err, 1'b0);
    check("rst_tick", frame_tick, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin check("pin_sel0", dig_sel, 4'b1110); check("pin_seg0", seg, 7'b1000000); end
      if (i == 4) begin check("pin_sel1", dig_sel, 4'b1101); check("pin_seg1", seg, 7'b0111111); end
      if (i == 7) check("pin_sel2", dig_sel, 4'b1011);
      if (i == 10) check("pin_sel3", dig_sel, 4'b0111);
      if (i == 11) check("pin_tick11", frame_tick, 1'b0);
      if (i == 12) check("pin_tick12", frame_tick, 1'b1);
    end

    doUpdate(5'b111_10);
    repeat (2) @(negedge clk);
    waitSel(4'b1110, "sel_d0_full");
    check("pin_seg_3", seg, 7'b0110000);
    waitSel(4'b1101, "sel_d1_full");
    check("pin_seg_A", seg, 7'b0001000);
    waitSel(4'b1011, "sel_d2_full");
    check("pin_seg_blank2", seg, 7'b1111111);
    check("pin_err_ok", err, 1'b0);

    doUpdate(5'b101_00);
    @(negedge clk);
    check("pin_err_set", err, 1'b1);
    @(negedge clk);
    waitSel(4'b1110, "sel_d0_err");
    check("pin_seg_E", seg, G_E);
    waitSel(4'b1101, "sel_d1_err");
    check("pin_seg_r", seg, G_R);
    waitOff("blink_off_1");

    doUpdate(5'b011_11);
    waitOff("blink_off_2");
    doUpdate(5'b011_01);
    @(negedge clk);
    check("pin_err_clear", err, 1'b0);
    @(negedge clk);
    waitSel(4'b1101, "sel_d1_clear");
    check("pin_seg_d", seg, G_D);

    for (int r = 0; r < 4; r++) begin
      int n = 0;
      while (((k + 1) % S) != 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      doUpdate(5'($urandom));
      repeat (2 * FRAME) @(negedge clk);
    end

    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 500; c++) begin
        {level_h, level_m, level_l, mode_asp, mode_gt} = 5'($urandom);
        update = ($urandom_range(0, (ph % 2) ? 120 : 10) == 0);
        @(negedge clk);
      end
    end
    update = 1'b0;

    doUpdate(5'b101_00);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_seg", seg, 7'h7F);
    check("async_sel", dig_sel, 4'hF);
    check("async_err", err, 1'b0);
    check("async_tick", frame_tick, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin check("rel_sel0", dig_sel, 4'b1110); check("rel_seg0", seg, 7'b1000000); end
      if (i == 4) begin check("rel_sel1", dig_sel, 4'b1101); check("rel_seg1", seg, G_DASH); end
    end
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
